// File: rtl/fcvt_issue_arbiter.sv
// Issue controller for the shared int/float conversion datapath.
// Round-robin over two requesters, one op register, 2-entry CDB buffer.
module fcvt_issue_arbiter #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_src,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_src,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [1:0]        cvt_op,
  output logic [DATA_W-1:0] cvt_src,
  input  logic [DATA_W-1:0] cvt_result,
  input  logic [4:0]        cvt_fflags,
  output logic              cdb_valid,
  input  logic              cdb_ready,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [4:0]        cdb_fflags,
  output logic              busy
);

  logic              s1_valid;
  logic [1:0]        s1_op;
  logic [DATA_W-1:0] s1_src;
  logic [TAG_W-1:0]  s1_tag;

  logic [DATA_W-1:0] fq_data  [2];
  logic [TAG_W-1:0]  fq_tag   [2];
  logic [4:0]        fq_flags [2];
  logic              head;
  logic [1:0]        count;
  logic              tail;

  logic rr;
  logic gnt_any;
  logic gnt_idx;
  logic pop;
  logic adv;
  logic push;
  logic can_acc;
  logic acc;

  assign pop     = cdb_valid & cdb_ready;
  assign adv     = s1_valid & ((count != 2'd2) | pop);
  assign push    = adv & ~flush;
  assign can_acc = ~flush & (~s1_valid | adv);
  // head + count modulo two
  assign tail    = head ^ count[0];

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    unique case (1'b1)
      (req0_valid & ~req1_valid): begin
        gnt_any = 1'b1;
        gnt_idx = 1'b0;
      end
      (req1_valid & ~req0_valid): begin
        gnt_any = 1'b1;
        gnt_idx = 1'b1;
      end
      (req0_valid & req1_valid): begin
        gnt_any = 1'b1;
        gnt_idx = rr;
      end
      default: begin
        gnt_any = 1'b0;
        gnt_idx = 1'b0;
      end
    endcase
  end

  // readies are forced low while reset is asserted
  assign req0_ready = rst_n & can_acc & gnt_any & ~gnt_idx;
  assign req1_ready = rst_n & can_acc & gnt_any & gnt_idx;
  assign acc        = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_src   <= '0;
      s1_tag   <= '0;
      rr       <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (acc) begin
      s1_valid <= 1'b1;
      s1_op    <= gnt_idx ? req1_op  : req0_op;
      s1_src   <= gnt_idx ? req1_src : req0_src;
      s1_tag   <= gnt_idx ? req1_tag : req0_tag;
      rr       <= ~gnt_idx;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fq_data[i]  <= '0;
        fq_tag[i]   <= '0;
        fq_flags[i] <= '0;
      end
    end else if (flush) begin
      head  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        fq_data[tail]  <= cvt_result;
        fq_tag[tail]   <= s1_tag;
        fq_flags[tail] <= cvt_fflags;
      end
      if (pop) begin
        head <= ~head;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign cvt_op     = s1_valid ? s1_op  : 2'b00;
  assign cvt_src    = s1_valid ? s1_src : '0;
  assign cdb_valid  = (count != 2'd0);
  assign cdb_data   = cdb_valid ? fq_data[head]  : '0;
  assign cdb_tag    = cdb_valid ? fq_tag[head]   : '0;
  assign cdb_fflags = cdb_valid ? fq_flags[head] : '0;
  assign busy       = s1_valid | cdb_valid;

endmodule

// File: tb/tb_fcvt_issue_arbiter.sv
// Bench for fcvt_issue_arbiter: directed scenarios, then random
// traffic checked against an in-order queue scoreboard.
module tb_fcvt_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [1:0]  req0_op = '0;
  logic [31:0] req0_src = '0;
  logic [4:0]  req0_tag = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [1:0]  req1_op = '0;
  logic [31:0] req1_src = '0;
  logic [4:0]  req1_tag = '0;
  logic [1:0]  cvt_op;
  logic [31:0] cvt_src;
  logic [31:0] cvt_result;
  logic [4:0]  cvt_fflags;
  logic        cdb_valid;
  logic        cdb_ready = 1'b0;
  logic [31:0] cdb_data;
  logic [4:0]  cdb_tag;
  logic [4:0]  cdb_fflags;
  logic        busy;

  int checks = 0;
  int failures = 0;

  fcvt_issue_arbiter #(.TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_src(req0_src), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_src(req1_src), .req1_tag(req1_tag),
    .cvt_op(cvt_op), .cvt_src(cvt_src),
    .cvt_result(cvt_result), .cvt_fflags(cvt_fflags),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_data(cdb_data), .cdb_tag(cdb_tag),
    .cdb_fflags(cdb_fflags), .busy(busy)
  );

  always #5 clk = ~clk;

  // converter: real signed int->float for op 00, arbitrary map otherwise
  function automatic logic [36:0] cvt_model(input logic [1:0] op,
                                            input logic [31:0] src);
    logic        s;
    logic [31:0] m, rem, half;
    logic [7:0]  e;
    logic [23:0] mt;
    logic        nx;
    int          p, sh;
    if (op != 2'b00)
      return {src[4:0] ^ {3'b0, op}, src ^ 32'h5A5A0000 ^ {30'b0, op}};
    if (src == 32'd0) return 37'd0;
    s = src[31];
    m = s ? (32'd0 - src) : src;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = 8'(127 + p);
    nx = 1'b0;
    if (p <= 23) begin
      mt = 24'(m << (23 - p));
    end else begin
      sh = p - 23;
      mt = 24'(m >> sh);
      rem = m & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      nx = (rem != 32'd0);
      if (rem > half || (rem == half && mt[0])) begin
        mt = mt + 24'd1;
        if (mt == 24'd0) begin
          mt = 24'h800000;
          e = e + 8'd1;
        end
      end
    end
    return {4'b0, nx, s, e, mt[22:0]};
  endfunction

  always_comb {cvt_fflags, cvt_result} = cvt_model(cvt_op, cvt_src);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic scen1();
    logic [36:0] r;
    cdb_ready = 1'b1;
    req0_valid = 1'b1;
    req0_op = 2'b00;
    req0_src = 32'hFFFFFFFF;
    req0_tag = 5'd3;
    #2;
    chk("s1_ready_c0", 64'(req0_ready), 64'd1);
    chk("s1_cdbv_c0", 64'(cdb_valid), 64'd0);
    cyc();
    req0_valid = 1'b0;
    #2;
    chk("s1_cvt_src_c1", 64'(cvt_src), 64'hFFFFFFFF);
    chk("s1_cdbv_c1", 64'(cdb_valid), 64'd0);
    cyc();
    #2;
    r = cvt_model(2'b00, 32'hFFFFFFFF);
    chk("s1_cdbv_c2", 64'(cdb_valid), 64'd1);
    chk("s1_data_c2", 64'(cdb_data), 64'hBF800000);
    chk("s1_model_c2", 64'(r[31:0]), 64'hBF800000);
    chk("s1_tag_c2", 64'(cdb_tag), 64'd3);
    cyc();
    #2;
    chk("s1_cdbv_c3", 64'(cdb_valid), 64'd0);
    chk("s1_busy_c3", 64'(busy), 64'd0);
    cyc();
  endtask

  logic [31:0] q_data[$];
  logic [4:0]  q_tag[$];
  logic [4:0]  q_flags[$];

  initial begin
    logic [31:0] srcs[3];
    logic [31:0] exps[3];
    logic [36:0] r;
    int n;
    logic rr_m;
    logic pop_m, can_m, g, a0, a1, h0, h1;

    do_reset();

    // scenario 1: single op latency
    scen1();

    // scenario 2: back-to-back
    srcs[0] = 32'h00000005; srcs[1] = 32'h0; srcs[2] = 32'h80000000;
    exps[0] = 32'h40A00000; exps[1] = 32'h0; exps[2] = 32'hCF000000;
    for (int c = 0; c < 6; c++) begin
      req0_valid = (c < 3);
      if (c < 3) begin
        req0_src = srcs[c];
        req0_tag = 5'(c + 1);
      end
      #2;
      if (c < 3) chk($sformatf("b2b_ready%0d", c), 64'(req0_ready), 64'd1);
      if (c >= 2 && c < 5) begin
        chk($sformatf("b2b_v%0d", c), 64'(cdb_valid), 64'd1);
        chk($sformatf("b2b_d%0d", c), 64'(cdb_data), 64'(exps[c-2]));
        chk($sformatf("b2b_t%0d", c), 64'(cdb_tag), 64'(c - 1));
      end
      if (c == 5) chk("b2b_v5", 64'(cdb_valid), 64'd0);
      cyc();
    end

    // scenario 3: round robin
    do_reset();
    cdb_ready = 1'b1;
    req0_op = 2'b01;
    req1_op = 2'b10;
    for (int c = 0; c < 9; c++) begin
      req0_valid = 1'b1;
      req1_valid = !(c == 6 || c == 7);
      req0_src = $urandom;
      req1_src = $urandom;
      #2;
      if (c < 6) begin
        chk($sformatf("rr_g0_%0d", c), 64'(req0_ready), 64'(c % 2 == 0));
        chk($sformatf("rr_g1_%0d", c), 64'(req1_ready), 64'(c % 2 == 1));
      end else if (c < 8) begin
        chk($sformatf("rr_solo_%0d", c), 64'(req0_ready), 64'd1);
      end else begin
        chk("rr_fav1_r1", 64'(req1_ready), 64'd1);
        chk("rr_fav1_r0", 64'(req0_ready), 64'd0);
      end
      cyc();
    end
    idle_inputs();
    repeat (4) cyc();

    // scenario 4: backpressure, capacity 3
    do_reset();
    cdb_ready = 1'b0;
    req0_op = 2'b00;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      req0_valid = 1'b1;
      req0_src = 32'(100 + n);
      req0_tag = 5'(n);
      #2;
      chk($sformatf("bp_ready%0d", c), 64'(req0_ready), 64'(c < 3));
      if (req0_ready) n++;
      cyc();
    end
    cdb_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      req0_valid = (j < 3);
      req0_src = 32'(100 + n);
      req0_tag = 5'(n);
      #2;
      r = cvt_model(2'b00, 32'(100 + j));
      if (j < 3) chk($sformatf("bp_resume%0d", j), 64'(req0_ready), 64'd1);
      chk($sformatf("bp_v%0d", j), 64'(cdb_valid), 64'd1);
      chk($sformatf("bp_d%0d", j), 64'(cdb_data), 64'(r[31:0]));
      chk($sformatf("bp_t%0d", j), 64'(cdb_tag), 64'(j));
      if (req0_ready) n++;
      cyc();
    end
    idle_inputs();
    #2;
    chk("bp_drained", 64'(cdb_valid), 64'd0);
    cyc();

    // scenario 5: flush
    do_reset();
    cdb_ready = 1'b0;
    req0_op = 2'b00;
    for (int c = 0; c < 2; c++) begin
      req0_valid = 1'b1;
      req0_src = 32'(7 + c);
      req0_tag = 5'(c);
      #2;
      chk($sformatf("fl_acc%0d", c), 64'(req0_ready), 64'd1);
      cyc();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_op = 2'b00;
    req1_src = 32'd9;
    req1_tag = 5'd17;
    flush = 1'b1;
    #2;
    chk("fl_busy_pre", 64'(busy), 64'd1);
    chk("fl_r1_during", 64'(req1_ready), 64'd0);
    chk("fl_r0_during", 64'(req0_ready), 64'd0);
    cyc();
    flush = 1'b0;
    cdb_ready = 1'b1;
    #2;
    chk("fl_cdbv_after", 64'(cdb_valid), 64'd0);
    chk("fl_busy_after", 64'(busy), 64'd0);
    chk("fl_r1_after", 64'(req1_ready), 64'd1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    #2;
    chk("fl_res_v", 64'(cdb_valid), 64'd1);
    chk("fl_res_d", 64'(cdb_data), 64'h41100000);
    chk("fl_res_t", 64'(cdb_tag), 64'd17);
    cyc();

    // scenario 6: async reset with 3 ops buffered
    do_reset();
    cdb_ready = 1'b0;
    req0_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req0_src = 32'(50 + c);
      #2;
      chk($sformatf("ar_fill%0d", c), 64'(req0_ready), 64'(c < 3));
      if (c < 3) cyc();
    end
    rst_n = 1'b0;
    #1;
    chk("ar_r0", 64'(req0_ready), 64'd0);
    chk("ar_cdbv", 64'(cdb_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_cvtsrc", 64'(cvt_src), 64'd0);
    chk("ar_cdbd", 64'(cdb_data), 64'd0);
    idle_inputs();
    cyc();
    rst_n = 1'b1;
    cdb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("ar_stale%0d", c), 64'(cdb_valid), 64'd0);
      cyc();
    end
    scen1();

    // random phase with scoreboard
    do_reset();
    rr_m = 1'b0;
    h0 = 1'b0;
    h1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!h0) begin
        req0_valid = ($urandom_range(2) != 0);
        req0_op = 2'($urandom);
        req0_src = $urandom;
        req0_tag = 5'($urandom);
      end
      if (!h1) begin
        req1_valid = ($urandom_range(2) != 0);
        req1_op = 2'($urandom);
        req1_src = $urandom;
        req1_tag = 5'($urandom);
      end
      flush = ($urandom_range(39) == 0);
      cdb_ready = ($urandom_range(9) < 7);
      #2;
      pop_m = cdb_valid & cdb_ready;
      can_m = !flush && (q_data.size() < 3 || pop_m);
      g = (req0_valid && req1_valid) ? rr_m : req1_valid;
      a0 = can_m && req0_valid && !g;
      a1 = can_m && req1_valid && g;
      chk("rnd_r0", 64'(req0_ready), 64'(a0));
      chk("rnd_r1", 64'(req1_ready), 64'(a1));
      chk("rnd_busy", 64'(busy), 64'(q_data.size() != 0));
      if (q_data.size() == 0) chk("rnd_empty", 64'(cdb_valid), 64'd0);
      if (q_data.size() >= 2) chk("rnd_full", 64'(cdb_valid), 64'd1);
      if (pop_m) begin
        if (q_data.size() == 0) begin
          chk("rnd_spurious", 64'(cdb_valid), 64'd0);
        end else begin
          chk("rnd_data", 64'(cdb_data), 64'(q_data[0]));
          chk("rnd_tag", 64'(cdb_tag), 64'(q_tag[0]));
          chk("rnd_flags", 64'(cdb_fflags), 64'(q_flags[0]));
          void'(q_data.pop_front());
          void'(q_tag.pop_front());
          void'(q_flags.pop_front());
        end
      end
      if (flush) begin
        q_data.delete();
        q_tag.delete();
        q_flags.delete();
      end else if (a0 || a1) begin
        r = a1 ? cvt_model(req1_op, req1_src) : cvt_model(req0_op, req0_src);
        q_data.push_back(r[31:0]);
        q_tag.push_back(a1 ? req1_tag : req0_tag);
        q_flags.push_back(r[36:32]);
        rr_m = !a1;
      end
      h0 = req0_valid && !req0_ready;
      h1 = req1_valid && !req1_ready;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
